// File: rtl/omsp_spm_violation_ctrl_if.sv
// Signal bundle between the SPM violation controller and its surroundings.
// master = SPM control / frontend / software side, slave = the violation controller.
interface omsp_spm_violation_ctrl_if #(
   parameter int CNT_WIDTH = 8
);
   // Handshake: violation is a level and one event per rising edge;
   // irq_acc and viol_clr are one-cycle strobes with no back-pressure.
   logic                 violation;
   logic [15:0]          spm_current_id;
   logic [15:0]          pc;
   logic [15:0]          eu_mab;
   logic                 irq_acc;
   logic                 viol_clr;
   logic                 viol_irq;
   logic                 viol_rst_req;
   logic                 viol_pending;
   logic [15:0]          viol_pc;
   logic [15:0]          viol_addr;
   logic [15:0]          viol_id;
   logic [CNT_WIDTH-1:0] viol_count;
   logic [1:0]           viol_state;

   modport master (
      output violation, spm_current_id, pc, eu_mab, irq_acc, viol_clr,
      input  viol_irq, viol_rst_req, viol_pending, viol_pc, viol_addr, viol_id,
             viol_count, viol_state
   );

   modport slave (
      input  violation, spm_current_id, pc, eu_mab, irq_acc, viol_clr,
      output viol_irq, viol_rst_req, viol_pending, viol_pc, viol_addr, viol_id,
             viol_count, viol_state
   );
endinterface

// File: rtl/omsp_spm_violation_ctrl.sv
// SPM violation controller: first-fault capture, interrupt, escalation to a stretched reset request.
// Define SPM_VIOLATION_IRQ_EN to build the interrupt path; otherwise every fault goes straight to reset.
module omsp_spm_violation_ctrl #(
   parameter int RST_PULSE_CYCLES = 4,
   parameter int CNT_WIDTH        = 8
) (
   input  logic                          mclk,
   input  logic                          puc_rst,
   omsp_spm_violation_ctrl_if.slave      bus
);
   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_IRQ_PEND = 2'd1,
      S_HANDLER  = 2'd2,
      S_RST_HOLD = 2'd3
   } state_t;

   localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;
   localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
   localparam logic [7:0]           RST_LOAD = 8'(RST_PULSE_CYCLES - 1);

   state_t     state;
   logic       viol_q;
   logic       viol_evt;
   logic [7:0] rst_cnt;

   assign viol_evt       = bus.violation & ~viol_q;
   assign bus.viol_state = state;

`ifndef SPM_VIOLATION_IRQ_EN
   logic unused_strobes;
   assign unused_strobes = bus.irq_acc ^ bus.viol_clr;
`endif

   always_ff @(posedge mclk or posedge puc_rst) begin
      if (puc_rst) viol_q <= 1'b0;
      else         viol_q <= bus.violation;
   end

   // Counts every event regardless of FSM state, sticking at all-ones.
   always_ff @(posedge mclk or posedge puc_rst) begin
      if (puc_rst)
         bus.viol_count <= '0;
      else if (viol_evt && (bus.viol_count != CNT_MAX))
         bus.viol_count <= bus.viol_count + CNT_ONE;
   end

   always_ff @(posedge mclk or posedge puc_rst) begin
      if (puc_rst) begin
         state            <= S_IDLE;
         bus.viol_irq     <= 1'b0;
         bus.viol_rst_req <= 1'b0;
         bus.viol_pending <= 1'b0;
         bus.viol_pc      <= 16'h0;
         bus.viol_addr    <= 16'h0;
         bus.viol_id      <= 16'h0;
         rst_cnt          <= 8'd0;
      end else begin
         case (state)
            S_IDLE: begin
               if (viol_evt) begin
                  bus.viol_pc      <= bus.pc;
                  bus.viol_addr    <= bus.eu_mab;
                  bus.viol_id      <= bus.spm_current_id;
                  bus.viol_pending <= 1'b1;
`ifdef SPM_VIOLATION_IRQ_EN
                  state            <= S_IRQ_PEND;
                  bus.viol_irq     <= 1'b1;
`else
                  state            <= S_RST_HOLD;
                  bus.viol_rst_req <= 1'b1;
                  rst_cnt          <= RST_LOAD;
`endif
               end
            end
`ifdef SPM_VIOLATION_IRQ_EN
            S_IRQ_PEND: begin
               if (viol_evt) begin
                  state            <= S_RST_HOLD;
                  bus.viol_irq     <= 1'b0;
                  bus.viol_rst_req <= 1'b1;
                  rst_cnt          <= RST_LOAD;
               end else if (bus.viol_clr) begin
                  state            <= S_IDLE;
                  bus.viol_irq     <= 1'b0;
                  bus.viol_pending <= 1'b0;
               end else if (bus.irq_acc) begin
                  state            <= S_HANDLER;
                  bus.viol_irq     <= 1'b0;
               end
            end
            S_HANDLER: begin
               // A second fault outranks the handler's clear.
               if (viol_evt) begin
                  state            <= S_RST_HOLD;
                  bus.viol_rst_req <= 1'b1;
                  rst_cnt          <= RST_LOAD;
               end else if (bus.viol_clr) begin
                  state            <= S_IDLE;
                  bus.viol_pending <= 1'b0;
               end
            end
`endif
            S_RST_HOLD: begin
               if (rst_cnt == 8'd0) begin
                  state            <= S_IDLE;
                  bus.viol_rst_req <= 1'b0;
                  bus.viol_pending <= 1'b0;
               end else begin
                  rst_cnt          <= rst_cnt - 8'd1;
               end
            end
            default: begin
               state            <= S_IDLE;
               bus.viol_irq     <= 1'b0;
               bus.viol_rst_req <= 1'b0;
               bus.viol_pending <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_omsp_spm_violation_ctrl.sv
// Bench for omsp_spm_violation_ctrl: directed vectors, a per-cycle reference model
// and literal checks; a second instance with a 2-bit counter covers saturation.
module tb_omsp_spm_violation_ctrl;
   localparam int RST_CYC = 4;

   logic mclk = 1'b0;
   logic puc_rst;
   int   checks = 0;
   int   errors = 0;

   omsp_spm_violation_ctrl_if #(.CNT_WIDTH(8)) bus_a ();
   omsp_spm_violation_ctrl_if #(.CNT_WIDTH(2)) bus_b ();

   assign bus_b.violation      = bus_a.violation;
   assign bus_b.spm_current_id = bus_a.spm_current_id;
   assign bus_b.pc             = bus_a.pc;
   assign bus_b.eu_mab         = bus_a.eu_mab;
   assign bus_b.irq_acc        = bus_a.irq_acc;
   assign bus_b.viol_clr       = bus_a.viol_clr;

   omsp_spm_violation_ctrl #(.RST_PULSE_CYCLES(RST_CYC), .CNT_WIDTH(8)) dut_a (
      .mclk(mclk), .puc_rst(puc_rst), .bus(bus_a)
   );
   omsp_spm_violation_ctrl #(.RST_PULSE_CYCLES(RST_CYC), .CNT_WIDTH(2)) dut_b (
      .mclk(mclk), .puc_rst(puc_rst), .bus(bus_b)
   );

   // ---------------- clock / reset ----------------
   always #5 mclk = ~mclk;

   // ---------------- checker ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // Fault status kept as: interrupt outstanding, handler running, reset cycles left.
   bit          m_prev, m_irq, m_hdl;
   int          m_rst_left;
   int unsigned m_cnt_a, m_cnt_b;
   logic [15:0] m_pc, m_addr, m_id;

   always @(posedge mclk or posedge puc_rst) begin
      if (puc_rst) begin
         m_prev = 0; m_irq = 0; m_hdl = 0; m_rst_left = 0;
         m_cnt_a = 0; m_cnt_b = 0;
         m_pc = 16'h0; m_addr = 16'h0; m_id = 16'h0;
      end else begin
         bit ev;
         ev = bus_a.violation && !m_prev;
         m_prev = bus_a.violation;
         if (ev) begin
            if (m_cnt_a < 255) m_cnt_a++;
            if (m_cnt_b < 3) m_cnt_b++;
         end
         if (m_rst_left > 0) begin
            m_rst_left--;
         end else if (m_irq) begin
            if (ev) begin m_irq = 0; m_rst_left = RST_CYC; end
            else if (bus_a.viol_clr) m_irq = 0;
            else if (bus_a.irq_acc) begin m_irq = 0; m_hdl = 1; end
         end else if (m_hdl) begin
            if (ev) begin m_hdl = 0; m_rst_left = RST_CYC; end
            else if (bus_a.viol_clr) m_hdl = 0;
         end else if (ev) begin
            m_pc = bus_a.pc; m_addr = bus_a.eu_mab; m_id = bus_a.spm_current_id;
`ifdef SPM_VIOLATION_IRQ_EN
            m_irq = 1;
`else
            m_rst_left = RST_CYC;
`endif
         end
      end
   end

   // ---------------- scoreboard: every cycle ----------------
   always @(negedge mclk) begin
      chk("irq",     32'(bus_a.viol_irq),     32'(m_irq));
      chk("rst_req", 32'(bus_a.viol_rst_req), 32'(m_rst_left > 0));
      chk("pending", 32'(bus_a.viol_pending), 32'(m_irq || m_hdl || (m_rst_left > 0)));
      chk("pc",      32'(bus_a.viol_pc),      32'(m_pc));
      chk("addr",    32'(bus_a.viol_addr),    32'(m_addr));
      chk("id",      32'(bus_a.viol_id),      32'(m_id));
      chk("count",   32'(bus_a.viol_count),   m_cnt_a);
      chk("count_w2", 32'(bus_b.viol_count),  m_cnt_b);
      chk("irq_rst_excl", 32'(bus_a.viol_irq & bus_a.viol_rst_req), 32'd0);
   end

   // ---------------- drivers ----------------
   task automatic cyc(input logic v, input logic acc, input logic clr);
      bus_a.violation = v;
      bus_a.irq_acc   = acc;
      bus_a.viol_clr  = clr;
      @(posedge mclk); #2;
      bus_a.irq_acc   = 1'b0;
      bus_a.viol_clr  = 1'b0;
   endtask

   task automatic ctx(input logic [15:0] p, input logic [15:0] a, input logic [15:0] id);
      bus_a.pc = p; bus_a.eu_mab = a; bus_a.spm_current_id = id;
   endtask

   task automatic do_reset();
      bus_a.violation = 1'b0; bus_a.irq_acc = 1'b0; bus_a.viol_clr = 1'b0;
      puc_rst = 1'b1;
      @(posedge mclk); #2;
      puc_rst = 1'b0;
   endtask

   // Counts reset-request cycles from the current one until it drops (bounded).
   task automatic rst_len(input string name, input int exp);
      int n;
      int guard;
      n = bus_a.viol_rst_req ? 1 : 0;
      guard = 0;
      while (bus_a.viol_rst_req && guard < 20) begin
         cyc(1'b0, 1'b0, 1'b0);
         if (bus_a.viol_rst_req) n++;
         guard++;
      end
      chk(name, 32'(n), 32'(exp));
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      puc_rst = 1'b1;
      ctx(16'h0, 16'h0, 16'h0);
      bus_a.violation = 1'b0; bus_a.irq_acc = 1'b0; bus_a.viol_clr = 1'b0;
      repeat (2) @(posedge mclk);
      #2;
      puc_rst = 1'b0;
      chk("reset_count", 32'(bus_a.viol_count), 32'd0);
      chk("reset_state", 32'(bus_a.viol_state), 32'd0);

      // Single fault, level held 3 cycles.
      ctx(16'h8123, 16'h0200, 16'h0002);
      cyc(1'b1, 1'b0, 1'b0);
      chk("single_pc",    32'(bus_a.viol_pc),   32'h8123);
      chk("single_addr",  32'(bus_a.viol_addr), 32'h0200);
      chk("single_id",    32'(bus_a.viol_id),   32'h0002);
      chk("single_count", 32'(bus_a.viol_count), 32'd1);
`ifdef SPM_VIOLATION_IRQ_EN
      chk("single_irq", 32'(bus_a.viol_irq), 32'd1);
      cyc(1'b1, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 1'b0);
      chk("held_count", 32'(bus_a.viol_count), 32'd1);
      ctx(16'h1111, 16'h2222, 16'h0003);
      cyc(1'b0, 1'b1, 1'b0);
      chk("acc_irq",     32'(bus_a.viol_irq),     32'd0);
      chk("acc_pending", 32'(bus_a.viol_pending), 32'd1);
      cyc(1'b0, 1'b0, 1'b1);
      chk("clr_pending", 32'(bus_a.viol_pending), 32'd0);
      chk("clr_pc_kept", 32'(bus_a.viol_pc),      32'h8123);
`else
      chk("single_irq",  32'(bus_a.viol_irq),     32'd0);
      chk("single_rreq", 32'(bus_a.viol_rst_req), 32'd1);
      cyc(1'b1, 1'b1, 1'b0);
      cyc(1'b1, 1'b0, 1'b1);
      chk("held_count", 32'(bus_a.viol_count), 32'd1);
      ctx(16'h1111, 16'h2222, 16'h0003);
      cyc(1'b0, 1'b0, 1'b0);
      chk("rreq_c4", 32'(bus_a.viol_rst_req), 32'd1);
      cyc(1'b0, 1'b0, 1'b0);
      chk("rreq_done",   32'(bus_a.viol_rst_req), 32'd0);
      chk("done_pending", 32'(bus_a.viol_pending), 32'd0);
      chk("done_pc_kept", 32'(bus_a.viol_pc),      32'h8123);
`endif

      // Escalation: second fault while the first is still outstanding.
      do_reset();
      ctx(16'h8123, 16'h0200, 16'h0002);
`ifdef SPM_VIOLATION_IRQ_EN
      cyc(1'b1, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, 1'b0);
      ctx(16'h9000, 16'h0300, 16'h0004);
      cyc(1'b1, 1'b0, 1'b0);
`else
      cyc(1'b1, 1'b0, 1'b0);
      ctx(16'h9000, 16'h0300, 16'h0004);
      cyc(1'b0, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 1'b0);
`endif
      chk("esc_pc_kept", 32'(bus_a.viol_pc),    32'h8123);
      chk("esc_count",   32'(bus_a.viol_count), 32'd2);
      chk("esc_irq",     32'(bus_a.viol_irq),   32'd0);
`ifdef SPM_VIOLATION_IRQ_EN
      rst_len("esc_rst_len", RST_CYC);
`else
      rst_len("esc_rst_len", RST_CYC - 2);
`endif
      chk("esc_idle_pending", 32'(bus_a.viol_pending), 32'd0);

      // Simultaneous strobes.
      do_reset();
`ifdef SPM_VIOLATION_IRQ_EN
      cyc(1'b1, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, 1'b0);
      cyc(1'b1, 1'b0, 1'b1);
      chk("hdl_ev_clr_rreq", 32'(bus_a.viol_rst_req), 32'd1);
      rst_len("hdl_ev_clr_len", RST_CYC);
      cyc(1'b0, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, 1'b1);
      chk("pend_acc_clr_irq",     32'(bus_a.viol_irq),     32'd0);
      chk("pend_acc_clr_pending", 32'(bus_a.viol_pending), 32'd0);
`else
      cyc(1'b1, 1'b1, 1'b1);
      chk("strobes_ignored_irq",  32'(bus_a.viol_irq),     32'd0);
      chk("strobes_ignored_rreq", 32'(bus_a.viol_rst_req), 32'd1);
      rst_len("strobes_ignored_len", RST_CYC);
`endif

      // Saturation: five separate events, mixed with strobes.
      do_reset();
      for (int i = 0; i < 5; i++) begin
         cyc(1'b1, i[0], i[1]);
         cyc(1'b0, 1'b0, 1'b0);
      end
      chk("sat_w2", 32'(bus_b.viol_count), 32'd3);
      chk("sat_w8", 32'(bus_a.viol_count), 32'd5);

      // Reset in the middle of a reset-hold.
      do_reset();
      ctx(16'hABCD, 16'h0456, 16'h0007);
`ifdef SPM_VIOLATION_IRQ_EN
      cyc(1'b1, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 1'b0);
`else
      cyc(1'b1, 1'b0, 1'b0);
`endif
      cyc(1'b0, 1'b0, 1'b0);
      chk("pre_rst_rreq", 32'(bus_a.viol_rst_req), 32'd1);
      puc_rst = 1'b1;
      #1;
      chk("mid_rst_rreq",    32'(bus_a.viol_rst_req), 32'd0);
      chk("mid_rst_pending", 32'(bus_a.viol_pending), 32'd0);
      chk("mid_rst_pc",      32'(bus_a.viol_pc),      32'd0);
      chk("mid_rst_count",   32'(bus_a.viol_count),   32'd0);
      @(posedge mclk); #2;
      puc_rst = 1'b0;
      cyc(1'b0, 1'b0, 1'b0);
      chk("post_rst_state", 32'(bus_a.viol_state), 32'd0);

      repeat (2) cyc(1'b0, 1'b0, 1'b0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/omsp_spm_violation_ctrl.md
# omsp_spm_violation_ctrl

Downstream consumer of the SPM control block's `violation` output. Detects each new violation, captures first-fault context (PC, memory address, current SM ID), and raises an interrupt towards the frontend. A second violation before software clears the first escalates to a stretched reset request. A saturating counter tracks the total number of violations seen since reset.

## Interface
Parameters:
- `RST_PULSE_CYCLES`, 4: number of cycles `viol_rst_req` is held high (legal range 1..255).
- `CNT_WIDTH`, 8: width of the violation counter.

Ports:
- `mclk`  in  1  system clock.
- `puc_rst`  in  1  reset: asynchronous, active-high.
- `violation`  in  1  combinational violation flag from SPM control.
- `spm_current_id`  in  16  ID of the currently executing SM.
- `pc`  in  16  current program counter.
- `eu_mab`  in  16  execution-unit memory address bus.
- `irq_acc`  in  1  one-cycle interrupt-accept strobe from the frontend.
- `viol_clr`  in  1  one-cycle software clear strobe (peripheral write).
- `viol_irq`  out  1  violation interrupt request.
- `viol_rst_req`  out  1  reset request towards the clock/reset module.
- `viol_pending`  out  1  captured fault not yet cleared.
- `viol_pc`  out  16  PC at the first fault.
- `viol_addr`  out  16  `eu_mab` at the first fault.
- `viol_id`  out  16  `spm_current_id` at the first fault.
- `viol_count`  out  CNT_WIDTH  saturating count of violation events.

## Operation
- Edge detect: `viol_q` registers `violation`. An event is `violation & ~viol_q`. A level held high counts as exactly one event.
- FSM states: IDLE, IRQ_PEND, HANDLER, RST_HOLD.
  - IDLE, on event: capture `pc`, `eu_mab`, `spm_current_id`, then go to IRQ_PEND.
  - IRQ_PEND: `viol_irq`=1.
    - `viol_clr` goes to IDLE, with priority over `irq_acc`.
    - else `irq_acc` goes to HANDLER.
    - event goes to RST_HOLD, with priority over both.
  - HANDLER: `viol_clr` goes to IDLE. An event goes to RST_HOLD; the event wins over a simultaneous `viol_clr`.
  - RST_HOLD: `viol_rst_req`=1. A down-counter is loaded with `RST_PULSE_CYCLES-1` on entry and decremented each cycle. At 0 the FSM goes to IDLE. Events in RST_HOLD neither restart the counter nor recapture.
- Capture registers load only on the IDLE→IRQ_PEND transition (first fault). They hold their value through escalation and clear. They are overwritten only by the next IDLE event.
- `viol_pending` = (state is IRQ_PEND, HANDLER or RST_HOLD).
- `viol_count` increments on every event in any state and saturates at all-ones (no wrap).
- `viol_irq` and `viol_rst_req` are never high in the same cycle.

## Timing
- All outputs are registered. Reset values: state IDLE, `viol_irq`=0, `viol_rst_req`=0, `viol_pending`=0, `viol_pc`/`viol_addr`/`viol_id`=16'h0, `viol_count`=0, `viol_q`=0.
- An event sampled at edge N gives `viol_irq`, `viol_pending` and captures valid from edge N+1 (1-cycle latency).
- `irq_acc` or `viol_clr` sampled at edge N deasserts `viol_irq` from N+1.
- Escalation at edge N: `viol_rst_req` is high for exactly `RST_PULSE_CYCLES` cycles starting at N+1, then IDLE.
- `puc_rst` mid-operation (including during RST_HOLD) returns everything to reset values immediately. Captured context is lost by design.

## Configuration
- `SPM_VIOLATION_IRQ_EN` defined: behaviour as above.
- Undefined: IRQ_PEND and HANDLER are not built and `viol_irq` is tied 0. Every event in IDLE captures context and goes directly to RST_HOLD. `irq_acc` and `viol_clr` are ignored.

## Test plan
- Reset: assert `puc_rst` mid-RST_HOLD → all outputs 0 and IDLE next cycle.
- Single fault: `violation` high 3 cycles with `pc`=16'h8123, `eu_mab`=16'h0200, `spm_current_id`=16'h0002 → one cycle later `viol_irq`=1, captures match, `viol_count`=1. Then `irq_acc` → `viol_irq`=0, pending=1. Then `viol_clr` → pending=0, captures retained.
- Escalation: fault, `irq_acc`, then second fault with `pc`=16'h9000 → `viol_rst_req` high exactly 4 cycles, `viol_pc` still 16'h8123, `viol_count`=2, then IDLE.
- Simultaneous events:
  - event + `viol_clr` in HANDLER → RST_HOLD.
  - `irq_acc` + `viol_clr` in IRQ_PEND → IDLE.
- Saturation: `CNT_WIDTH`=2, 5 events → `viol_count`=3.
- Macro off: single fault → `viol_irq` stays 0, `viol_rst_req` high 4 cycles, captures valid.
